mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W, default 28, line address width (word address bits minus 2); DATA_W, default 128, memory beat width; BEATS, default 4, beats per cache line.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-low.
REQ-004 reqN_val / reqN_rdy  in/out  1/1  request handshake for client N (N=0 icache, N=1 dcache).
REQ-005 reqN_addr / reqN_rw  in  ADDR_W/1  client N line address and write flag (1=write).
REQ-006 reqN_data_valid / reqN_data_ready  in/out  1/1  client N write-data beat handshake.
REQ-007 reqN_data_bits / reqN_data_mask  in  DATA_W/DATA_W/8  client N write beat and byte mask.
REQ-008 respN_val / respN_data  out  1/DATA_W  read beat routed to client N.
REQ-009 mem_req_val, mem_req_rdy, mem_req_addr, mem_req_rw  out/in/out/out  1/1/ADDR_W/1  memory request port.
REQ-010 mem_req_data_valid, mem_req_data_ready, mem_req_data_bits, mem_req_data_mask  out/in/out/out  1/1/DATA_W/DATA_W/8  memory write-data port.
REQ-011 mem_resp_val / mem_resp_data  in  1/DATA_W  memory read beat.
REQ-012 err_spurious_resp  out  1  sticky flag, mem_resp_val seen with no read outstanding.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WDATA, RRESP; exactly one transaction in flight.
REQ-014 IDLE: if any reqN_val, latch grant and go to REQ next cycle (1-cycle arbitration latency); else stay.
REQ-015 Grant SHALL be round-robin: both valid -> client not granted last; one valid -> that client.
REQ-016 REQ: mem_req_val/addr/rw SHALL come from the latched client only; grant SHALL NOT change while in REQ.
REQ-017 reqN_rdy SHALL equal (state==REQ) & (grant==N) & mem_req_rdy; fire goes to WDATA if rw=1, else RRESP.
REQ-018 WDATA: mem_req_data_* SHALL mirror the granted client; reqN_data_ready = mem_req_data_ready for granted client only; after BEATS fired beats go to IDLE.
REQ-019 RRESP: each mem_resp_val SHALL produce respN_val, same cycle, for the granted client only, data unmodified; after BEATS beats go to IDLE.
REQ-020 Beat counter SHALL be log2(BEATS) bits, clear on entering WDATA/RRESP, wrap to 0 on last beat.
REQ-021 Non-granted client SHALL see rdy, data_ready, resp_val all 0.
REQ-022 mem_resp_val outside RRESP SHALL be dropped and set err_spurious_resp until reset.
REQ-023 IDLE->REQ with the other client arriving in the same cycle SHALL not affect the current grant; it wins the next arbitration.

Reset
REQ-024 Reset assertion SHALL immediately force IDLE, counter 0, last-grant=1 (client 0 wins first tie), err flag 0, all val/rdy outputs 0, including mid-transaction.
REQ-025 Data/address outputs SHALL be 0 whenever their valid is 0.

Configuration
REQ-026 MEM_ARB_PERF_EN defined: outputs perf_grant0, perf_grant1 (32 bits each) count fired requests per client, saturating at all-ones, cleared by reset.
REQ-027 MEM_ARB_PERF_EN undefined: perf ports absent, no counter logic.

Structure
REQ-028 Package mem_arb_pkg SHALL hold the state enum, default ADDR_W/DATA_W/BEATS, and client IDs.
REQ-029 Round-robin pick SHALL be sub-module mem_arb_rr_pick (inputs: two valids, last grant; output: grant).

Verification
REQ-030 Client 1 read 0x0000040, mem_req_rdy=1 -> mem_req_val cycle 1, addr 0x0000040 rw=0; four resp beats 0xA..0xD -> resp1_val x4, resp0_val never.
REQ-031 Both clients valid from reset -> client 0 granted first, then client 1, then alternating.
REQ-032 Client 0 write, 4 beats, mask 0xFFFF, mem_req_data_ready toggling 1/0 -> exactly 4 beats on memory, back in IDLE after 4th.
REQ-033 mem_resp_val pulse in IDLE -> no respN_val, err_spurious_resp=1 and held.
REQ-034 Reset asserted after beat 2 of a read -> next cycle IDLE, all valids 0; new request then completes normally.
REQ-035 With MEM_ARB_PERF_EN: 3 reads client 0, 2 writes client 1 -> perf_grant0=3, perf_grant1=2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-client (icache/dcache) memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_BEATS  = 4;

  localparam logic CLIENT_ICACHE = 1'b0;
  localparam logic CLIENT_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2,
    RRESP = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory request bundle: request handshake, write-data beats and read beats.
// The requester side is "master"; the arbiter faces clients as "slave" and memory as "master".
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic                  val;
  logic                  rdy;
  logic [ADDR_W-1:0]     addr;
  logic                  rw;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_W-1:0]     data_bits;
  logic [DATA_W/8-1:0]   data_mask;
  logic                  resp_val;
  logic [DATA_W-1:0]     resp_data;

  modport master (
    output val, addr, rw, data_valid, data_bits, data_mask,
    input  rdy, data_ready, resp_val, resp_data
  );

  modport slave (
    input  val, addr, rw, data_valid, data_bits, data_mask,
    output rdy, data_ready, resp_val, resp_data
  );

endinterface

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick: on a tie the client not granted last time wins.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic val0,
  input  logic val1,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = last_grant;
    if (val0 && val1) begin
      grant = ~last_grant;
    end else if (val0) begin
      grant = CLIENT_ICACHE;
    end else if (val1) begin
      grant = CLIENT_DCACHE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between icache (req0) and dcache (req1).
// Optional per-client grant counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS
)
(
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  req0,
  mem_arbiter_if.slave  req1,
  mem_arbiter_if.master mem,
  output logic          err_spurious_resp
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_grant0,
  output logic [31:0]   perf_grant1
`endif
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_e       state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pick;

  logic                sel_val, sel_rw, sel_dvalid;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_dbits;
  logic [DATA_W/8-1:0] sel_dmask;

  logic in_req, in_wdata, in_rresp;
  logic is_c0, is_c1;
  logic mem_val, mem_dvalid, resp0_val, resp1_val;
  logic req_fire, wbeat_fire, rbeat;

  mem_arb_rr_pick u_pick (
    .val0       (req0.val),
    .val1       (req1.val),
    .last_grant (last_grant_q),
    .grant      (pick)
  );

  assign is_c0 = (grant_q == CLIENT_ICACHE);
  assign is_c1 = (grant_q == CLIENT_DCACHE);

  assign sel_val    = is_c1 ? req1.val        : req0.val;
  assign sel_rw     = is_c1 ? req1.rw         : req0.rw;
  assign sel_addr   = is_c1 ? req1.addr       : req0.addr;
  assign sel_dvalid = is_c1 ? req1.data_valid : req0.data_valid;
  assign sel_dbits  = is_c1 ? req1.data_bits  : req0.data_bits;
  assign sel_dmask  = is_c1 ? req1.data_mask  : req0.data_mask;

  assign in_req   = (state_q == REQ);
  assign in_wdata = (state_q == WDATA);
  assign in_rresp = (state_q == RRESP);

  assign req_fire   = in_req & sel_val & mem.rdy;
  assign wbeat_fire = in_wdata & sel_dvalid & mem.data_ready;
  assign rbeat      = in_rresp & mem.resp_val;

  // Address and data buses are zeroed whenever their qualifying valid is low.
  assign mem_val         = in_req & sel_val;
  assign mem.val         = mem_val;
  assign mem.addr        = mem_val ? sel_addr : '0;
  assign mem.rw          = mem_val & sel_rw;
  assign mem_dvalid      = in_wdata & sel_dvalid;
  assign mem.data_valid  = mem_dvalid;
  assign mem.data_bits   = mem_dvalid ? sel_dbits : '0;
  assign mem.data_mask   = mem_dvalid ? sel_dmask : '0;

  assign req0.rdy        = in_req & is_c0 & mem.rdy;
  assign req1.rdy        = in_req & is_c1 & mem.rdy;
  assign req0.data_ready = in_wdata & is_c0 & mem.data_ready;
  assign req1.data_ready = in_wdata & is_c1 & mem.data_ready;

  assign resp0_val       = rbeat & is_c0;
  assign resp1_val       = rbeat & is_c1;
  assign req0.resp_val   = resp0_val;
  assign req1.resp_val   = resp1_val;
  assign req0.resp_data  = resp0_val ? mem.resp_data : '0;
  assign req1.resp_data  = resp1_val ? mem.resp_data : '0;

  assign err_spurious_resp = err_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    err_d        = err_q | (mem.resp_val & ~in_rresp);
    case (state_q)
      IDLE: begin
        if (req0.val || req1.val) begin
          grant_d      = pick;
          last_grant_d = pick;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (req_fire) begin
          state_d = sel_rw ? WDATA : RRESP;
          cnt_d   = '0;
        end
      end
      WDATA: begin
        if (wbeat_fire) begin
          cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = IDLE;
        end
      end
      RRESP: begin
        if (rbeat) begin
          cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Last grant resets to dcache so icache wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= CLIENT_ICACHE;
      last_grant_q <= CLIENT_DCACHE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf0_q, perf0_d, perf1_q, perf1_d;

  always_comb begin
    perf0_d = perf0_q;
    perf1_d = perf1_q;
    if (req_fire && is_c0 && (perf0_q != '1)) perf0_d = perf0_q + 32'd1;
    if (req_fire && is_c1 && (perf1_q != '1)) perf1_d = perf1_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf0_q <= '0;
      perf1_q <= '0;
    end else begin
      perf0_q <= perf0_d;
      perf1_q <= perf1_d;
    end
  end

  assign perf_grant0 = perf0_q;
  assign perf_grant1 = perf1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with reset pulses.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int BEATS  = 4;
  localparam int MASK_W = DATA_W / 8;

  logic clk = 1'b0;
  logic reset;
  logic err;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf0, perf1;
`endif

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c0 ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c1 ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk               (clk),
    .reset             (reset),
    .req0              (c0),
    .req1              (c1),
    .mem               (m),
    .err_spurious_resp (err)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_grant0       (perf0),
    .perf_grant1       (perf1)
`endif
  );

  int checks = 0;
  int passes = 0;
  int resp0_seen = 0;
  int resp1_seen = 0;
  int wbeats_seen = 0;

  // Transaction-level view: a grant waiting for memory to accept, then a beat countdown.
  bit          pend = 1'b0;
  bit          owner = 1'b0;
  int          beats_left = 0;
  bit          is_wr = 1'b0;
  bit          last_w = 1'b1;
  bit          err_m = 1'b0;
  int unsigned perf_m [2] = '{0, 0};

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend = 1'b0; owner = 1'b0; beats_left = 0; is_wr = 1'b0;
      last_w = 1'b1; err_m = 1'b0; perf_m[0] = 0; perf_m[1] = 0;
    end else begin
      bit ov, odv, orw;
      ov  = owner ? c1.val : c0.val;
      odv = owner ? c1.data_valid : c0.data_valid;
      orw = owner ? c1.rw : c0.rw;
      if (m.resp_val && !(beats_left > 0 && !is_wr)) err_m = 1'b1;
      if (!pend && beats_left == 0) begin
        if (c0.val || c1.val) begin
          owner  = (c0.val && c1.val) ? !last_w : !c0.val;
          last_w = owner;
          pend   = 1'b1;
        end
      end else if (pend) begin
        if (ov && m.rdy) begin
          pend       = 1'b0;
          beats_left = BEATS;
          is_wr      = orw;
          if (perf_m[owner] != 32'hFFFF_FFFF) perf_m[owner]++;
        end
      end else if (is_wr) begin
        if (odv && m.data_ready) beats_left--;
      end else if (m.resp_val) begin
        beats_left--;
      end
    end
  end

  task automatic checkOutput();
    logic ov, orw, odv, exp_mval, wph, rph, exp_dv, exp_r0, exp_r1;
    logic [ADDR_W-1:0] oaddr;
    logic [DATA_W-1:0] obits;
    logic [MASK_W-1:0] omask;
    ov     = owner ? c1.val : c0.val;
    orw    = owner ? c1.rw : c0.rw;
    odv    = owner ? c1.data_valid : c0.data_valid;
    oaddr  = owner ? c1.addr : c0.addr;
    obits  = owner ? c1.data_bits : c0.data_bits;
    omask  = owner ? c1.data_mask : c0.data_mask;
    exp_mval = pend && ov;
    wph    = (beats_left > 0) && is_wr;
    rph    = (beats_left > 0) && !is_wr;
    exp_dv = wph && odv;
    exp_r0 = rph && !owner && m.resp_val;
    exp_r1 = rph && owner && m.resp_val;
    check("mem_req_val", m.val, exp_mval);
    check("mem_req_addr", m.addr, exp_mval ? oaddr : '0);
    check("mem_req_rw", m.rw, exp_mval && orw);
    check("req0_rdy", c0.rdy, pend && !owner && m.rdy);
    check("req1_rdy", c1.rdy, pend && owner && m.rdy);
    check("mem_data_valid", m.data_valid, exp_dv);
    check("mem_data_bits", m.data_bits, exp_dv ? obits : '0);
    check("mem_data_mask", m.data_mask, exp_dv ? omask : '0);
    check("req0_data_ready", c0.data_ready, wph && !owner && m.data_ready);
    check("req1_data_ready", c1.data_ready, wph && owner && m.data_ready);
    check("resp0_val", c0.resp_val, exp_r0);
    check("resp1_val", c1.resp_val, exp_r1);
    check("resp0_data", c0.resp_data, exp_r0 ? m.resp_data : '0);
    check("resp1_data", c1.resp_data, exp_r1 ? m.resp_data : '0);
    check("err_spurious", err, err_m);
`ifdef MEM_ARB_PERF_EN
    check("perf_grant0", perf0, perf_m[0]);
    check("perf_grant1", perf1, perf_m[1]);
`endif
    if (c0.resp_val === 1'b1) resp0_seen++;
    if (c1.resp_val === 1'b1) resp1_seen++;
    if (m.data_valid === 1'b1 && m.data_ready === 1'b1) wbeats_seen++;
  endtask

  always @(negedge clk) checkOutput();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c0.val = 0; c0.addr = '0; c0.rw = 0; c0.data_valid = 0; c0.data_bits = '0; c0.data_mask = '0;
    c1.val = 0; c1.addr = '0; c1.rw = 0; c1.data_valid = 0; c1.data_bits = '0; c1.data_mask = '0;
    m.rdy = 0; m.data_ready = 0; m.resp_val = 0; m.resp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Waits (bounded) for the granted request, accepts it, then serves all beats.
  task automatic serve_txn(output int winner, input logic [DATA_W-1:0] data_base);
    bit wr;
    winner = -1;
    m.rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (c0.rdy === 1'b1 || c1.rdy === 1'b1) break;
      tick();
    end
    if (c0.rdy !== 1'b1 && c1.rdy !== 1'b1) begin
      check("req_rdy_timeout", 1'b0, 1'b1);
      return;
    end
    winner = (c1.rdy === 1'b1) ? 1 : 0;
    wr = (winner == 1) ? c1.rw : c0.rw;
    tick();
    m.rdy = 1'b0;
    if (wr) begin
      m.data_ready = 1'b1;
      for (int b = 0; b < BEATS; b++) begin
        if (winner == 1) begin
          c1.data_valid = 1'b1; c1.data_mask = '1; c1.data_bits = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          c0.data_valid = 1'b1; c0.data_mask = '1; c0.data_bits = {$urandom, $urandom, $urandom, $urandom};
        end
        tick();
      end
      c0.data_valid = 1'b0; c1.data_valid = 1'b0; m.data_ready = 1'b0;
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        m.resp_val = 1'b1;
        m.resp_data = data_base + DATA_W'(b);
        #1;
        check("resp_beat_data", (winner == 1) ? c1.resp_data : c0.resp_data, data_base + DATA_W'(b));
        tick();
      end
      m.resp_val = 1'b0;
    end
  endtask

  task automatic applyStimulus();
    c0.val = 1'($urandom); c0.addr = ADDR_W'($urandom); c0.rw = 1'($urandom);
    c0.data_valid = 1'($urandom); c0.data_bits = {$urandom, $urandom, $urandom, $urandom};
    c0.data_mask = MASK_W'($urandom);
    c1.val = 1'($urandom); c1.addr = ADDR_W'($urandom); c1.rw = 1'($urandom);
    c1.data_valid = 1'($urandom); c1.data_bits = {$urandom, $urandom, $urandom, $urandom};
    c1.data_mask = MASK_W'($urandom);
    m.rdy = 1'($urandom); m.data_ready = 1'($urandom);
    m.resp_val = ($urandom_range(0, 3) != 0); m.resp_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    int w;
    reset = 1'b0;
    idle_inputs();
    do_reset();
    check("reset_mem_val", m.val, 1'b0);
    check("reset_rdy0", c0.rdy, 1'b0);
    check("reset_err", err, 1'b0);

    // Client 1 read of line 0x40 with four response beats
    c1.val = 1'b1; c1.addr = 28'h0000040; c1.rw = 1'b0; m.rdy = 1'b1;
    tick();
    check("rd1_mem_val", m.val, 1'b1);
    check("rd1_mem_addr", m.addr, 28'h0000040);
    check("rd1_mem_rw", m.rw, 1'b0);
    resp0_seen = 0; resp1_seen = 0;
    serve_txn(w, 128'hA);
    c1.val = 1'b0;
    check("rd1_winner", w, 1);
    check("rd1_resp1_count", resp1_seen, 4);
    check("rd1_resp0_count", resp0_seen, 0);

    // Both clients requesting continuously from reset: strict alternation from client 0
    idle_inputs();
    do_reset();
    c0.val = 1'b1; c0.addr = 28'h111; c1.val = 1'b1; c1.addr = 28'h222;
    for (int t = 0; t < 4; t++) begin
      serve_txn(w, 128'h100);
      check("rr_order", w, t % 2);
    end
    idle_inputs();
    tick();

    // Client 0 write with memory data_ready toggling
    do_reset();
    c0.val = 1'b1; c0.rw = 1'b1; c0.addr = 28'h345; m.rdy = 1'b1;
    tick();
    check("wr_rdy0", c0.rdy, 1'b1);
    tick();
    c0.val = 1'b0; m.rdy = 1'b0;
    c0.data_valid = 1'b1; c0.data_mask = 16'hFFFF; c0.data_bits = 128'hDEAD_BEEF;
    wbeats_seen = 0;
    for (int i = 0; i < 8; i++) begin
      m.data_ready = (i % 2 == 0);
      if (i == 0) begin
        #1;
        check("wr_mask", m.data_mask, 16'hFFFF);
      end
      tick();
    end
    check("wr_beat_count", wbeats_seen, 4);
    check("wr_done_dvalid", m.data_valid, 1'b0);
    idle_inputs();

    // Spurious memory response while idle
    do_reset();
    check("spur_err_before", err, 1'b0);
    m.resp_val = 1'b1; m.resp_data = 128'h55;
    #1;
    check("spur_resp0", c0.resp_val, 1'b0);
    check("spur_resp1", c1.resp_val, 1'b0);
    tick();
    m.resp_val = 1'b0;
    check("spur_err_set", err, 1'b1);
    tick();
    tick();
    check("spur_err_held", err, 1'b1);

    // Reset in the middle of a read, then a fresh read completes
    do_reset();
    c0.val = 1'b1; c0.rw = 1'b0; c0.addr = 28'h123; m.rdy = 1'b1;
    tick();
    check("mid_rdy0", c0.rdy, 1'b1);
    tick();
    c0.val = 1'b0; m.rdy = 1'b0;
    m.resp_val = 1'b1; m.resp_data = 128'h7;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_resp0", c0.resp_val, 1'b0);
    check("mid_rst_mem_val", m.val, 1'b0);
    check("mid_rst_err", err, 1'b0);
    tick();
    reset = 1'b1;
    m.resp_val = 1'b0;
    c1.val = 1'b1; c1.rw = 1'b0; c1.addr = 28'h456;
    resp1_seen = 0;
    serve_txn(w, 128'h200);
    c1.val = 1'b0;
    check("mid_after_winner", w, 1);
    check("mid_after_resp1", resp1_seen, 4);
    idle_inputs();

`ifdef MEM_ARB_PERF_EN
    do_reset();
    c0.val = 1'b1; c0.rw = 1'b0;
    for (int t = 0; t < 3; t++) serve_txn(w, 128'h300);
    c0.val = 1'b0;
    c1.val = 1'b1; c1.rw = 1'b1;
    for (int t = 0; t < 2; t++) serve_txn(w, 128'h0);
    c1.val = 1'b0;
    tick();
    check("perf0_lit", perf0, 32'd3);
    check("perf1_lit", perf1, 32'd2);
    idle_inputs();
`endif

    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 400 == 399) begin
        reset = 1'b0;
        #2;
        reset = 1'b1;
      end
      applyStimulus();
      tick();
    end
    idle_inputs();
    tick();
    tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
